// File: rtl/record_pkg.sv
// Shared constants for the record unit.
package record_pkg;

    localparam int unsigned WORD_W    = 32;
    localparam int unsigned IDX_W     = 6;
    localparam int unsigned LAST_IDX  = 31;
    localparam logic [31:0] TOTAL_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/bit_sync.sv
// N-flop synchronizer for a single asynchronous bit, cleared by reset.
module bit_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    // Shift the raw bit through the synchronizer chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/record_unit.sv
// Serial-to-parallel capture: samples synchronized dIn on samplePulse while
// enabled, assembles MSB-first words and keeps a saturating ones count.
module record_unit #(
    parameter int unsigned WORD_W      = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              dIn,
    input  logic              samplePulse,
    input  logic              enable,
    output logic [WORD_W-1:0] recordedOut,
    output logic              dataValid,
    output logic [WORD_W-1:0] runningTotal,
    output logic [5:0]        incrementer
);

    import record_pkg::*;

    logic              din_s;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [WORD_W-1:0] total_q, total_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              valid_q, valid_d;

    bit_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (resetN),
        .d   (dIn),
        .q   (din_s)
    );

    // Next-state: sample on pulse while enabled; dropping enable discards the partial word.
    always_comb begin
        shreg_d = shreg_q;
        word_d  = word_q;
        total_d = total_q;
        idx_d   = idx_q;
        valid_d = 1'b0;
        if (!enable) begin
            shreg_d = '0;
            idx_d   = '0;
        end else if (samplePulse) begin
            if (din_s && (total_q != TOTAL_MAX)) begin
                total_d = total_q + 32'd1;
            end
            if (idx_q == IDX_W'(LAST_IDX)) begin
                word_d  = {shreg_q[WORD_W-2:0], din_s};
                valid_d = 1'b1;
                idx_d   = '0;
                shreg_d = '0;
            end else begin
                shreg_d = {shreg_q[WORD_W-2:0], din_s};
                idx_d   = idx_q + 6'd1;
            end
        end
    end

    // State registers; reset wins over any sample.
    always_ff @(posedge clk) begin
        if (resetN) begin
            shreg_q <= '0;
            word_q  <= '0;
            total_q <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            word_q  <= word_d;
            total_q <= total_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
        end
    end

    assign recordedOut  = word_q;
    assign dataValid    = valid_q;
    assign runningTotal = total_q;
    assign incrementer  = idx_q;

endmodule

// File: tb/tb_record_unit.sv
// Bench for record_unit: reference model plus table vectors and directed sequences.
module tb_record_unit;

    localparam int unsigned SYNC = 2;

    logic        clk = 1'b0;
    logic        resetN = 1'b1;
    logic        dIn = 1'b0;
    logic        samplePulse = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] recordedOut;
    logic        dataValid;
    logic [31:0] runningTotal;
    logic [5:0]  incrementer;

    int errors = 0;
    int checks = 0;
    int valid_cnt = 0;

    // Reference model state
    bit          m_pipe[$];
    bit          m_bits[$];
    logic [31:0] m_word = '0;
    logic        m_valid = 1'b0;
    logic [31:0] m_total = '0;

    typedef struct {
        logic        r, e, p, d;
        logic [5:0]  inc;
        logic [31:0] total;
        logic        valid;
    } vec_t;

    vec_t tbl[11];

    record_unit #(
        .WORD_W      (32),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk          (clk),
        .resetN       (resetN),
        .dIn          (dIn),
        .samplePulse  (samplePulse),
        .enable       (enable),
        .recordedOut  (recordedOut),
        .dataValid    (dataValid),
        .runningTotal (runningTotal),
        .incrementer  (incrementer)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model of one clock edge: delay-line synchronizer, bit queue, saturating count.
    function automatic void model_edge(input logic r, input logic e, input logic p,
                                       input logic d);
        bit s;
        s = m_pipe[SYNC-1];
        if (r) begin
            for (int i = 0; i < SYNC; i++) m_pipe[i] = 1'b0;
            m_bits.delete();
            m_word  = '0;
            m_valid = 1'b0;
            m_total = '0;
            return;
        end
        m_valid = 1'b0;
        if (!e) begin
            m_bits.delete();
        end else if (p) begin
            m_bits.push_back(s);
            if (s && m_total != 32'hFFFF_FFFF) m_total = m_total + 1;
            if (m_bits.size() == 32) begin
                for (int i = 0; i < 32; i++) m_word[31-i] = m_bits[i];
                m_valid = 1'b1;
                m_bits.delete();
            end
        end
        m_pipe.push_front(d);
        void'(m_pipe.pop_back());
    endfunction

    task automatic cycle(input logic r, input logic e, input logic p, input logic d,
                         input bit dly);
        resetN      = r;
        enable      = e;
        samplePulse = p;
        if (dly) #2;
        dIn = d;
        @(posedge clk);
        model_edge(r, e, p, d);
        #1;
        check("recordedOut", recordedOut, m_word);
        check("dataValid", {31'd0, dataValid}, {31'd0, m_valid});
        check("runningTotal", runningTotal, m_total);
        check("incrementer", {26'd0, incrementer}, m_bits.size());
        if (dataValid === 1'b1) valid_cnt++;
    endtask

    // Each bit held two cycles; a pulse every other cycle catches it after the synchronizer.
    task automatic send_bits(input logic [63:0] bits_v, input int n, input bit dly);
        for (int t = 0; t <= 2 * n + 1; t++) begin
            logic d;
            logic p;
            d = ((t / 2) < n) ? bits_v[n - 1 - (t / 2)] : 1'b0;
            p = ((t % 2) == 1) && (t >= 3);
            cycle(1'b0, 1'b1, p, d, dly);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int v0;
        logic [31:0] rword;

        for (int i = 0; i < SYNC; i++) m_pipe.push_back(1'b0);

        tbl[0]  = '{1'b0, 1'b0, 1'b1, 1'b1, 6'd0, 32'd0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 6'd0, 32'd0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 6'd1, 32'd1, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 6'd1, 32'd1, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 6'd2, 32'd2, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 32'd2, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 6'd1, 32'd2, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 6'd0, 32'd0, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 6'd1, 32'd0, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 6'd2, 32'd0, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 6'd3, 32'd1, 1'b0};

        // Reset held 9 cycles under random stimulus
        for (int i = 0; i < 9; i++)
            cycle(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'b0);
        // Disabled pulses change nothing
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
        check("disabled_total", runningTotal, 32'd0);
        check("disabled_inc", {26'd0, incrementer}, 32'd0);

        // Table vectors from a quiet state
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        foreach (tbl[i]) begin
            cycle(tbl[i].r, tbl[i].e, tbl[i].p, tbl[i].d, 1'b0);
            check($sformatf("tbl%0d_inc", i), {26'd0, incrementer}, {26'd0, tbl[i].inc});
            check($sformatf("tbl%0d_total", i), runningTotal, tbl[i].total);
            check($sformatf("tbl%0d_valid", i), {31'd0, dataValid}, {31'd0, tbl[i].valid});
        end

        // Single word
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        v0 = valid_cnt;
        send_bits({32'd0, 32'h03FD5501}, 32, 1'b0);
        check("word_value", recordedOut, 32'h03FD5501);
        check("word_valid_count", valid_cnt - v0, 32'd1);
        check("word_total", runningTotal, 32'd14);
        check("word_inc", {26'd0, incrementer}, 32'd0);

        // Partial word discarded by enable falling
        v0 = valid_cnt;
        send_bits({48'd0, 16'hC839}, 16, 1'b0);
        check("partial_inc_before", {26'd0, incrementer}, 32'd16);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("partial_no_valid", valid_cnt - v0, 32'd0);
        check("partial_word", recordedOut, 32'h03FD5501);
        check("partial_total", runningTotal, 32'd21);
        check("partial_inc", {26'd0, incrementer}, 32'd0);

        // Re-arm after reset: 33 bits
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rearm_reset_word", recordedOut, 32'd0);
        send_bits({31'd0, 32'h03FD5501, 1'b1}, 33, 1'b0);
        check("rearm_word", recordedOut, 32'h03FD5501);
        check("rearm_inc", {26'd0, incrementer}, 32'd1);
        check("rearm_total", runningTotal, 32'd15);

        // Data edges offset from the clock
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rword = $urandom;
        send_bits({32'd0, rword}, 32, 1'b1);
        check("async_word", recordedOut, rword);

        // Back-to-back words of all ones
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        v0 = valid_cnt;
        for (int i = 0; i < 64; i++) begin
            cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
            if (dataValid === 1'b1) check("b2b_word", recordedOut, 32'hFFFF_FFFF);
        end
        check("b2b_valid_count", valid_cnt - v0, 32'd2);

        // Saturation of the ones count
        force dut.total_q = 32'hFFFF_FFFD;
        #1;
        release dut.total_q;
        m_total = 32'hFFFF_FFFD;
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        check("saturated_total", runningTotal, 32'hFFFF_FFFF);

        // Random traffic against the model
        for (int i = 0; i < 1500; i++)
            cycle(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 9) != 0),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
